board_scan_controller: RTL
==========================

# board_scan_controller

Sequences the external 8x8 checkers-board sensor matrix on the PMOD header. It drives one row at a time, waits for the row to settle, and samples the 8 column lines. It debounces whole-board frames and exposes the accepted board state to the processor as a small read-only memory-mapped window. It sits between the PMOD pins and the data-memory read mux, alongside the sensor path that feeds `q_dmem`.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1000: cycles a row is driven before it is sampled; must be ≥ 3.
- `DEBOUNCE_N`, default 4: consecutive identical full-board frames required to accept a new board; must be ≥ 1.

Ports:
- `clock`  in  1: system clock; the only clock.
- `reset`  in  1: synchronous, active-low reset (0 = reset, sampled on the rising edge of `clock`).
- `enable`  in  1: scanning runs while high.
- `col_in`  in  8: raw column sense lines, asynchronous to `clock`.
- `changed_clr`  in  1: single-cycle pulse that clears `changed`.
- `offset`  in  2: word offset within the block's memory window (address decode is external).
- `row_sel`  out  3: index of the row being driven.
- `row_en`  out  1: row drive enable, active high.
- `board`  out  64: accepted board, bit `8*row+col`.
- `changed`  out  1: sticky flag, set when `board` takes a new value.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `scan_count`  out  16: completed full scans, wraps at 0xFFFF→0x0000.
- `rd_data`  out  32: combinational read data for `offset`.

## Operation
- `col_in` passes through a 2-flop synchronizer before any use.
- FSM states: IDLE, SELECT, SAMPLE, COMMIT.
- **IDLE**
  - `row_en`=0, `row_sel`=0.
  - If `enable`=1, go to SELECT with row 0 and the settle counter at 0.
- **SELECT**
  - `row_en`=1, `row_sel`=row.
  - Counts SETTLE_CYCLES cycles, then goes to SAMPLE.
- **SAMPLE**, one cycle, `row_en`=1:
  - `raw[row]` <= synchronized `col_in`.
  - If row < 7: row++ and go to SELECT.
  - If row = 7: go to COMMIT.
- **COMMIT**, one cycle, `row_en`=0:
  - If `raw` == `candidate`: `agree` <= min(`agree`+1, DEBOUNCE_N).
  - Otherwise: `candidate` <= `raw` and `agree` <= 1.
  - If the new `agree` == DEBOUNCE_N and `raw` != `board`: `board` <= `raw` and `changed` <= 1.
  - `scan_count`++ (wraps).
  - Next state is SELECT at row 0 if `enable`=1, else IDLE.
- `enable`=0 in any non-IDLE state:
  - Next state is IDLE.
  - Partial frame discarded, `agree` <= 0.
  - `board`, `candidate` and `scan_count` unchanged.
- `changed`:
  - Set in COMMIT as above.
  - Cleared by `changed_clr`.
  - If set and clear happen in the same cycle, set wins.
- `rd_data` by `offset`:
  - 0: `board[31:0]`
  - 1: `board[63:32]`
  - 2: {`scan_count`, 14'b0, `busy`, `changed`}
  - 3: 0
- Reset values:
  - FSM = IDLE, row = 0, `row_sel`=0, `row_en`=0, `busy`=0, `changed`=0, `scan_count`=0.
  - `board`, `raw`, `candidate` all 0; `agree`=0; synchronizer flops 0.
  - Consequently `rd_data` = 0 for every offset.

## Timing
- Each row occupies SETTLE_CYCLES + 1 cycles (SELECT then SAMPLE).
- A full scan takes 8·(SETTLE_CYCLES+1) + 1 cycles, measured from the first SELECT cycle through COMMIT.
- Scanning is back-to-back while `enable` stays high: COMMIT is followed directly by SELECT row 0.
- From `enable` rising in IDLE, `row_en` goes high 1 cycle later.
- `col_in` must be stable from the start of the SELECT cycle at `SETTLE_CYCLES`−2 through SAMPLE; this is the synchronizer latency of 2.
- `board`, `changed` and `scan_count` update on the clock edge that ends COMMIT.
- `rd_data` has zero latency: it is combinational from `offset` and registered state.
- `busy` is registered with the FSM state.
- Reset asserted mid-scan returns every output to its reset value on the next edge, regardless of `enable`.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles with `enable`=1 → `row_en`=0, `busy`=0, `scan_count`=0, `board`=0, `rd_data`=0 at `offset` 0..3.
- **Scan timing** (SETTLE=4, N=1): raise `enable`.
  - `row_sel` steps 0→7, holding each value 5 cycles.
  - `row_en` drops in COMMIT.
  - `scan_count`=1 exactly 41 cycles after the first SELECT cycle.
- **Debounce** (N=3): `col_in`=0x81 for every row.
  - `board` stays 0 after scans 1 and 2.
  - After scan 3, `board`=0x8181818181818181 and `changed`=1.
  - Reading offset 0 gives 0x81818181; offset 2 gives 0x00030003.
- **Glitch rejection** (N=3, board settled at the 0x81 pattern): present `col_in`=0xFF on row 3 for one scan, then 0x81 again.
  - `board` never changes and `changed` stays 0 after `changed_clr`.
- **Abort:** drop `enable` while `row_sel`=4.
  - Next cycle: IDLE, `row_en`=0, `busy`=0, `scan_count` unchanged.
  - Re-raise `enable` → scanning restarts at row 0, and acceptance again requires N full agreeing scans.
- **Flag/counter corners:**
  - Assert `changed_clr` in the COMMIT cycle that sets `changed` → `changed`=1.
  - A lone `changed_clr` → `changed`=0.
  - Run scans so that `scan_count` goes 0xFFFF → 0x0000.

Source files
------------

// File: rtl/board_scan_controller.sv
// Row-sequenced scanner for the 8x8 board sensor matrix: drives one row at a time,
// samples the columns, debounces whole frames and exposes the result as a 4-word window.
module board_scan_controller #(
    parameter int SETTLE_CYCLES = 1000,
    parameter int DEBOUNCE_N    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  col_in,
    input  logic        changed_clr,
    input  logic [1:0]  offset,
    output logic [2:0]  row_sel,
    output logic        row_en,
    output logic [63:0] board,
    output logic        changed,
    output logic        busy,
    output logic [15:0] scan_count,
    output logic [31:0] rd_data
);

    localparam int CNT_W   = $clog2(SETTLE_CYCLES + 1);
    localparam int AGREE_W = $clog2(DEBOUNCE_N + 1);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        SAMPLE,
        COMMIT
    } state_t;

    state_t               state_reg;
    logic [2:0]           row_reg;
    logic [CNT_W-1:0]     settle_reg;
    logic [7:0]           sync1_reg;
    logic [7:0]           sync2_reg;
    logic [63:0]          raw_reg;
    logic [63:0]          candidate_reg;
    logic [63:0]          board_reg;
    logic [AGREE_W-1:0]   agree_reg;
    logic                 changed_reg;
    logic                 row_en_reg;
    logic [2:0]           row_sel_reg;
    logic                 busy_reg;
    logic [15:0]          scan_count_reg;

    logic                 frame_match;
    logic [AGREE_W-1:0]   agree_next;
    logic                 accept;

    // Column lines are asynchronous; nothing downstream sees them unsynchronized.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_reg <= 8'd0;
            sync2_reg <= 8'd0;
        end else begin
            sync1_reg <= col_in;
            sync2_reg <= sync1_reg;
        end
    end

    // Debounce decision for the frame that just finished; only consumed in COMMIT.
    always_comb begin
        frame_match = (raw_reg == candidate_reg);
        agree_next  = AGREE_W'(1);
        if (frame_match) begin
            if (agree_reg >= AGREE_W'(DEBOUNCE_N))
                agree_next = AGREE_W'(DEBOUNCE_N);
            else
                agree_next = agree_reg + AGREE_W'(1);
        end
        accept = (agree_next == AGREE_W'(DEBOUNCE_N)) && (raw_reg != board_reg);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg      <= IDLE;
            row_reg        <= 3'd0;
            settle_reg     <= '0;
            raw_reg        <= 64'd0;
            candidate_reg  <= 64'd0;
            board_reg      <= 64'd0;
            agree_reg      <= '0;
            changed_reg    <= 1'b0;
            row_en_reg     <= 1'b0;
            row_sel_reg    <= 3'd0;
            busy_reg       <= 1'b0;
            scan_count_reg <= 16'd0;
        end else begin
            if (changed_clr)
                changed_reg <= 1'b0;

            // Dropping enable mid-frame throws the partial frame away and
            // restarts the agreement count from scratch.
            if (!enable && (state_reg == SELECT || state_reg == SAMPLE)) begin
                state_reg   <= IDLE;
                row_reg     <= 3'd0;
                settle_reg  <= '0;
                agree_reg   <= '0;
                row_en_reg  <= 1'b0;
                row_sel_reg <= 3'd0;
                busy_reg    <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (enable) begin
                            state_reg   <= SELECT;
                            row_reg     <= 3'd0;
                            settle_reg  <= '0;
                            row_en_reg  <= 1'b1;
                            row_sel_reg <= 3'd0;
                            busy_reg    <= 1'b1;
                        end
                    end
                    SELECT: begin
                        if (settle_reg == CNT_W'(SETTLE_CYCLES - 1)) begin
                            state_reg  <= SAMPLE;
                            settle_reg <= '0;
                        end else begin
                            settle_reg <= settle_reg + CNT_W'(1);
                        end
                    end
                    SAMPLE: begin
                        raw_reg[8*row_reg +: 8] <= sync2_reg;
                        if (row_reg == 3'd7) begin
                            state_reg  <= COMMIT;
                            row_en_reg <= 1'b0;
                        end else begin
                            state_reg   <= SELECT;
                            row_reg     <= row_reg + 3'd1;
                            row_sel_reg <= row_reg + 3'd1;
                        end
                    end
                    COMMIT: begin
                        agree_reg <= agree_next;
                        if (!frame_match)
                            candidate_reg <= raw_reg;
                        if (accept) begin
                            board_reg   <= raw_reg;
                            changed_reg <= 1'b1;
                        end
                        scan_count_reg <= scan_count_reg + 16'd1;
                        row_reg        <= 3'd0;
                        settle_reg     <= '0;
                        row_sel_reg    <= 3'd0;
                        if (enable) begin
                            state_reg  <= SELECT;
                            row_en_reg <= 1'b1;
                            busy_reg   <= 1'b1;
                        end else begin
                            state_reg  <= IDLE;
                            row_en_reg <= 1'b0;
                            busy_reg   <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg   <= IDLE;
                        row_en_reg  <= 1'b0;
                        row_sel_reg <= 3'd0;
                        busy_reg    <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (offset)
            2'd0:    rd_data = board_reg[31:0];
            2'd1:    rd_data = board_reg[63:32];
            2'd2:    rd_data = {scan_count_reg, 14'd0, busy_reg, changed_reg};
            default: rd_data = 32'd0;
        endcase
    end

    assign row_sel    = row_sel_reg;
    assign row_en     = row_en_reg;
    assign board      = board_reg;
    assign changed    = changed_reg;
    assign busy       = busy_reg;
    assign scan_count = scan_count_reg;

endmodule
